// File: rtl/marker_binarizer_if.sv
// Pixel-in / mask-out stream bundle for marker_binarizer.
// The source side (camera feed plus mask sink) is the master; the binarizer is the slave.
`timescale 1ns/1ps
interface marker_binarizer_if;
  logic       i_valid;
  logic [7:0] i_r;
  logic [7:0] i_g;
  logic [7:0] i_b;
  logic       o_valid;
  logic       o_data;

  modport master (
    output i_valid, i_r, i_g, i_b,
    input  o_valid, o_data
  );

  modport slave (
    input  i_valid, i_r, i_g, i_b,
    output o_valid, o_data
  );
endinterface

// File: rtl/marker_binarizer.sv
// Colour-window threshold followed by a causal 3x3 vote filter over two 1-bit line buffers.
// One output per input, same raster order, fixed two-cycle latency.
`timescale 1ns/1ps
module marker_binarizer #(
  parameter int WIDTH  = 800,
  parameter int HEIGHT = 600,
  parameter int R_MIN  = 160,
  parameter int G_MAX  = 96,
  parameter int B_MAX  = 96,
  parameter int VOTE   = 6
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  marker_binarizer_if.slave   px
);

  localparam int         AW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [9:0] COL_LAST = 10'(WIDTH - 1);
  localparam logic [9:0] ROW_LAST = 10'(HEIGHT - 1);
  localparam logic [7:0] R_MIN_V  = 8'(R_MIN);
  localparam logic [7:0] G_MAX_V  = 8'(G_MAX);
  localparam logic [7:0] B_MAX_V  = 8'(B_MAX);
  localparam logic [3:0] VOTE_V   = 4'(VOTE);

  // Raster position of the pixel currently presented on the input.
  logic [9:0] row;
  logic [9:0] col;

  // Stage 1: thresholded bit with its position.
  logic       s1_valid;
  logic       s1_mark;
  logic [9:0] s1_row;
  logic [9:0] s1_col;

  // Stage 2: line buffers (lb1 = previous row, lb0 = the row before) and the 3x3 window.
  // win[2] is the newest column; within a column bit 0 is row r, bit 2 is row r-2.
  logic             lb0 [WIDTH];
  logic             lb1 [WIDTH];
  logic [AW-1:0]    lb_addr;
  logic [2:0]       col_vec;
  logic [2:0][2:0]  win;
  logic [2:0][2:0]  win_next;
  logic [3:0]       vote_cnt;
  logic             pix_mark;

  function automatic logic [3:0] popcount9(input logic [8:0] bits);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 9; i++) begin
      n = n + {3'b000, bits[i]};
    end
    return n;
  endfunction

  assign pix_mark = (px.i_r >= R_MIN_V) && (px.i_g <= G_MAX_V) && (px.i_b <= B_MAX_V);

  // NOTE: every clocked process uses non-blocking assignments so all registers
  // sample pre-edge values; blocking here would chain stages within one edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      row <= '0;
      col <= '0;
    end else if (px.i_valid) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 10'd1;
      end else begin
        col <= col + 10'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid <= 1'b0;
      s1_mark  <= 1'b0;
      s1_row   <= '0;
      s1_col   <= '0;
    end else begin
      s1_valid <= px.i_valid;
      if (px.i_valid) begin
        s1_mark <= pix_mark;
        s1_row  <= row;
        s1_col  <= col;
      end
    end
  end

  assign lb_addr = s1_col[AW-1:0];

  // NOTE: the line buffers are plain RAM with no reset; stale rows from an earlier
  // frame or from before a reset are hidden by the row<1 / row<2 masks below.
  always_ff @(posedge i_clk) begin
    if (s1_valid) begin
      lb0[lb_addr] <= lb1[lb_addr];
      lb1[lb_addr] <= s1_mark;
    end
  end

  // NOTE: every output of this block is given a default before any branch so no
  // path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    col_vec  = {lb0[lb_addr] & (s1_row >= 10'd2),
                lb1[lb_addr] & (s1_row != 10'd0),
                s1_mark};
    win_next = win;
    if (s1_valid) begin
      // Column 0 starts a fresh row: older columns belong to the previous row's right edge.
      if (s1_col == 10'd0) win_next = {col_vec, 3'b000, 3'b000};
      else                 win_next = {col_vec, win[2], win[1]};
    end
  end

  assign vote_cnt = popcount9(win_next);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      win        <= '0;
      px.o_valid <= 1'b0;
      px.o_data  <= 1'b0;
    end else begin
      win        <= win_next;
      px.o_valid <= s1_valid;
      if (s1_valid) begin
        px.o_data <= (vote_cnt >= VOTE_V);
      end
    end
  end

endmodule

// File: tb/tb_marker_binarizer.sv
// Bench for marker_binarizer: four instances (VOTE 6/1/2/9) share one pixel stream and are
// checked every cycle against a frame-image model, plus hand-computed per-frame totals.
`timescale 1ns/1ps
module tb_marker_binarizer;

  localparam int W    = 16;
  localparam int H    = 12;
  localparam int NPIX = W * H;

  typedef enum int {K_UNIFORM, K_SINGLE, K_BLOCK, K_EDGE_IN, K_R_LOW, K_G_HIGH, K_B_HIGH} kind_e;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] pr = '0, pg = '0, pb = '0;
  logic [3:0] ov, od;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic int vote_of(input int k);
    return (k == 0) ? 6 : (k == 1) ? 1 : (k == 2) ? 2 : 9;
  endfunction

  for (genvar k = 0; k < 4; k++) begin : g_dut
    marker_binarizer_if bus ();
    assign bus.i_valid = valid;
    assign bus.i_r     = pr;
    assign bus.i_g     = pg;
    assign bus.i_b     = pb;
    assign ov[k]       = bus.o_valid;
    assign od[k]       = bus.o_data;
    marker_binarizer #(
      .WIDTH(W), .HEIGHT(H), .R_MIN(160), .G_MAX(96), .B_MAX(96),
      .VOTE((k == 0) ? 6 : (k == 1) ? 1 : (k == 2) ? 2 : 9)
    ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .px(bus)
    );
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: frame image and 3x3 causal window count ----------------
  bit   mk [H][W];
  int   exp_q [$];
  bit [1:0] vpipe;
  int   mr, mc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vpipe = '0;
      exp_q.delete();
      mr = 0;
      mc = 0;
    end else begin
      vpipe = {vpipe[0], valid};
      if (valid) begin
        int cnt;
        mk[mr][mc] = (pr >= 8'd160) && (pg <= 8'd96) && (pb <= 8'd96);
        cnt = 0;
        for (int rr = mr - 2; rr <= mr; rr++)
          for (int cc = mc - 2; cc <= mc; cc++)
            if (rr >= 0 && cc >= 0 && mk[rr][cc]) cnt++;
        exp_q.push_back(cnt);
        mc++;
        if (mc == W) begin
          mc = 0;
          mr = (mr == H - 1) ? 0 : mr + 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare, plus DUT output tallies ----------------
  bit last_d [4];
  int pulses [4];
  int ones   [4];
  int last_one [4];
  bit rec    [NPIX];
  bit golden [NPIX];

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("reset_o_valid[v%0d]", vote_of(k)), ov[k], 0);
        check($sformatf("reset_o_data[v%0d]", vote_of(k)), od[k], 0);
        last_d[k] = 1'b0;
        pulses[k] = 0;
        ones[k] = 0;
        last_one[k] = -1;
      end
    end else begin
      int  cnt;
      bit  ev;
      ev  = vpipe[1];
      cnt = 0;
      if (ev) begin
        if (exp_q.size() == 0) check("model_queue_nonempty", 0, 1);
        else cnt = exp_q.pop_front();
      end
      for (int k = 0; k < 4; k++) begin
        check($sformatf("o_valid[v%0d]", vote_of(k)), ov[k], ev);
        if (ev) begin
          last_d[k] = (cnt >= vote_of(k));
          check($sformatf("o_data[v%0d]", vote_of(k)), od[k], last_d[k]);
        end else begin
          check($sformatf("o_data_hold[v%0d]", vote_of(k)), od[k], last_d[k]);
        end
        if (ov[k]) begin
          if (k == 0 && pulses[0] < NPIX) rec[pulses[0]] = od[0];
          if (od[k]) begin
            ones[k]++;
            last_one[k] = pulses[k];
          end
          pulses[k]++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [23:0] pix(input kind_e kd, input int r, input int c);
    logic [23:0] mkr;
    logic [23:0] bg;
    bit at;
    mkr = 24'hFF0000;
    bg  = 24'h000000;
    at  = (r == 5 && c == 7);
    case (kd)
      K_UNIFORM: return mkr;
      K_SINGLE:  return at ? mkr : bg;
      K_BLOCK:   return (r >= 5 && r <= 7 && c >= 7 && c <= 9) ? mkr : bg;
      K_EDGE_IN: return at ? {8'd160, 8'd96, 8'd96} : bg;
      K_R_LOW:   return at ? {8'd159, 8'd0, 8'd0} : bg;
      K_G_HIGH:  return at ? {8'd255, 8'd97, 8'd0} : bg;
      K_B_HIGH:  return at ? {8'd255, 8'd0, 8'd97} : bg;
      default:   return bg;
    endcase
  endfunction

  task automatic drive_frame(input kind_e kd, input int npix, input bit gapped);
    for (int i = 0; i < npix; i++) begin
      {pr, pg, pb} = pix(kd, (i / W) % H, i % W);
      valid = 1'b1;
      @(posedge clk); #1;
      if (gapped) begin
        valid = 1'b0;
        {pr, pg, pb} = 24'($urandom);
        @(posedge clk); #1;
      end
    end
    valid = 1'b0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid = i[0];
      {pr, pg, pb} = 24'hFF0000;
      @(posedge clk); #1;
    end
    valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int diffs;
    // Reset held with i_valid toggling; the compare process checks outputs stay low.
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      valid = i[0];
    end
    valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // First valid after release appears on o_valid two cycles later.
    {pr, pg, pb} = 24'h000000;
    valid = 1'b1;
    lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk); #1;
      valid = 1'b0;
      if (ov[0]) begin
        lat = i;
        break;
      end
    end
    check("first_output_latency", lat, 2);

    // Uniform marker frame.
    apply_reset();
    drive_frame(K_UNIFORM, NPIX, 1'b0);
    drain();
    check("uniform_pulses", pulses[0], NPIX);
    check("uniform_ones_v6", ones[0], (H - 1) * (W - 1) - 1);
    check("uniform_ones_v1", ones[1], NPIX);
    check("uniform_ones_v2", ones[2], NPIX - 1);
    for (int i = 0; i < NPIX; i++) golden[i] = rec[i];

    // Uniform frame then single pixel frame back to back: stale line buffers must be masked.
    apply_reset();
    drive_frame(K_UNIFORM, NPIX, 1'b0);
    drive_frame(K_SINGLE, NPIX, 1'b0);
    drain();
    check("two_frame_pulses", pulses[1], 2 * NPIX);
    check("single_ones_v1", ones[1], NPIX + 9);
    check("single_last_one_v1", last_one[1], NPIX + 7 * W + 9);
    check("single_ones_v2", ones[2], NPIX - 1);

    // 3x3 block, only the window fully covering it passes VOTE=9.
    apply_reset();
    drive_frame(K_BLOCK, NPIX, 1'b0);
    drain();
    check("block_ones_v9", ones[3], 1);
    check("block_pos_v9", last_one[3], 7 * W + 9);

    // Threshold edges.
    apply_reset();
    drive_frame(K_EDGE_IN, NPIX, 1'b0);
    drain();
    check("edge_in_ones_v1", ones[1], 9);
    apply_reset();
    drive_frame(K_R_LOW, NPIX, 1'b0);
    drain();
    check("r159_ones_v1", ones[1], 0);
    apply_reset();
    drive_frame(K_G_HIGH, NPIX, 1'b0);
    drain();
    check("g97_ones_v1", ones[1], 0);
    apply_reset();
    drive_frame(K_B_HIGH, NPIX, 1'b0);
    drain();
    check("b97_ones_v1", ones[1], 0);

    // Gapped input up to mid-frame, reset, then a clean frame identical to the first uniform one.
    apply_reset();
    drive_frame(K_UNIFORM, (H / 2) * W + 5, 1'b1);
    apply_reset();
    drive_frame(K_UNIFORM, NPIX, 1'b0);
    drain();
    check("post_reset_pulses", pulses[0], NPIX);
    check("post_reset_ones_v6", ones[0], (H - 1) * (W - 1) - 1);
    diffs = 0;
    for (int i = 0; i < NPIX; i++) if (rec[i] != golden[i]) diffs++;
    check("post_reset_bit_identical", diffs, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/marker_binarizer.md
# marker_binarizer

Upstream stage of the corner finder. It converts the camera's raster RGB pixel stream into the one-bit marker mask that the corner finder consumes. Each valid pixel is thresholded against a fixed colour window. The result is cleaned with a causal 3x3 vote filter built from two one-bit line buffers. The block emits exactly one valid output per valid input, in the same raster order and with fixed latency, so downstream row/column counting stays aligned.

## Interface
Parameters:
- WIDTH, 800, pixels per row; the column counter wraps at WIDTH-1.
- HEIGHT, 600, rows per frame; the row counter wraps at HEIGHT-1.
- R_MIN, 160, minimum red value for a marker pixel (inclusive).
- G_MAX, 96, maximum green value (inclusive).
- B_MAX, 96, maximum blue value (inclusive).
- VOTE, 6, minimum number of marker bits in the 3x3 window for o_data=1; legal range 1..9.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  qualifies i_r/i_g/i_b as the next raster pixel.
- i_r, i_g, i_b  in  8 each  pixel colour.
- o_valid  out  1  qualifies o_data; drives the corner finder's i_valid.
- o_data  out  1  filtered marker bit; drives the corner finder's i_data.

## Operation
- Input counters: row and col are 10-bit and start at (0,0).
  - Each i_valid cycle, col increments.
  - At col=WIDTH-1, col goes to 0 and row increments.
  - At (HEIGHT-1, WIDTH-1), both go to 0 (frame wrap).
  - Cycles without i_valid change no state.
- Stage 1 (threshold), registered on i_valid:
  - m = (i_r>=R_MIN) && (i_g<=G_MAX) && (i_b<=B_MAX).
  - The stage registers m together with the pixel's row and col.
- Stage 2 (window):
  - Two line buffers of WIDTH bits each, indexed by column.
    - lb1[c] holds row r-1.
    - lb0[c] holds row r-2.
  - On each stage-1 valid at (r,c), the block reads lb1[c] and lb0[c] to form the column vector {lb0[c], lb1[c], m}.
    - lb0 bit is masked to 0 when r<2.
    - lb1 bit is masked to 0 when r<1.
  - The block then writes lb0[c]=lb1[c] and lb1[c]=m.
  - A 3x3 register window shifts left by one column and loads the new vector into its rightmost column.
  - When c=0, the two older window columns are cleared before the shift, giving zero padding at the left edge.
- Vote: count the ones in the 9 window bits (4-bit count) and set o_data = (count >= VOTE).
- Output convention: o_data for input position (r,c) is the filter result over inputs rows r-2..r, cols c-2..c, which is centred on (r-1,c-1). The one-pixel diagonal offset is accepted downstream.
- Line buffer contents are never cleared. Stale data from the previous frame is masked by the row<2 rule.
- Reset at any time clears:
  - counters;
  - pipeline valids;
  - window;
  - o_valid and o_data.

  The next valid input after reset is pixel (0,0).

## Timing
- Reset values: o_valid=0, o_data=0, row=col=0, window=0.
- Latency: o_valid equals i_valid delayed exactly 2 cycles. o_data is registered alongside o_valid.
- There is no backpressure; the block accepts i_valid every cycle.
- Gapped input is allowed and keeps its pattern: the o_valid gap pattern equals the i_valid gap pattern.
- When o_valid=0, o_data holds its last value. Downstream ignores it.
- Each frame of WIDTH*HEIGHT valid inputs produces exactly WIDTH*HEIGHT o_valid pulses.
- The line buffer read and write for the same column happen in the same cycle. The read returns the old contents.

## Test plan
- Reset: hold i_rst_n=0 with i_valid toggling -> o_valid=0 and o_data=0 throughout. After release, the first o_valid appears 2 cycles after the first i_valid.
- Uniform marker frame (all pixels R=255, G=0, B=0), VOTE=6 -> o_data=0 for:
  - all of row 0;
  - row 1 cols 0-1;
  - col 0 of every row.

  o_data=1 everywhere else. Exactly 480000 o_valid pulses.
- Single marker pixel at (100,200), rest black, VOTE=1 -> o_data=1 exactly at positions rows 100-102 × cols 200-202 (9 pulses). With VOTE=2, no ones.
- 3x3 marker block at rows 100-102, cols 200-202, VOTE=9 -> exactly one o_data=1, at (102,202).
- Threshold edges (each tested as a single pixel with VOTE=1):
  - R=160, G=96, B=96 -> marker.
  - R=159, or G=97, or B=97 -> not marker.
- i_valid every other cycle through a frame, followed by reset asserted mid-frame (row 300) and a full clean frame -> o_valid mirrors i_valid delayed by 2, and the post-reset frame output is bit-identical to the uniform-marker-frame result.
